// File: rtl/ysyx_23060208_sram_rd_arbiter.sv
// Two-requester read arbiter (IFU = requester 0, LSU = requester 1) in front of
// a single SRAM AR/R port. One transaction in flight; the owner is locked from
// grant until its R handshake, and simultaneous requests alternate round-robin.
module ysyx_23060208_sram_rd_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // IFU
    input  logic [ADDR_WIDTH-1:0] ifu_araddr,
    input  logic                  ifu_arvalid,
    output logic                  ifu_arready,
    output logic [DATA_WIDTH-1:0] ifu_rdata,
    output logic [1:0]            ifu_rresp,
    output logic                  ifu_rvalid,
    input  logic                  ifu_rready,
    // LSU
    input  logic [ADDR_WIDTH-1:0] lsu_araddr,
    input  logic                  lsu_arvalid,
    output logic                  lsu_arready,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic [1:0]            lsu_rresp,
    output logic                  lsu_rvalid,
    input  logic                  lsu_rready,
    // SRAM
    output logic [ADDR_WIDTH-1:0] s_araddr,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    input  logic [1:0]            s_rresp,
    input  logic                  s_rvalid,
    output logic                  s_rready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;   // 0 = IFU, 1 = LSU
    logic   last_q,  last_d;    // requester that completed most recently

    // Requesters gathered into index-by-id vectors so the per-port muxing is uniform.
    logic [1:0]            req_arvalid;
    logic [1:0]            req_rready;
    logic [1:0]            req_arready;
    logic [1:0]            req_rvalid;
    logic [ADDR_WIDTH-1:0] req_araddr [2];

    assign req_arvalid   = {lsu_arvalid, ifu_arvalid};
    assign req_rready    = {lsu_rready,  ifu_rready};
    assign req_araddr[0] = ifu_araddr;
    assign req_araddr[1] = lsu_araddr;

    // Handshake returns go only to the registered owner; never gated by arvalid
    // combinationally, so arbitration always costs one IDLE cycle.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            localparam logic REQ_ID = (gi == 1);
            assign req_arready[gi] = (state_q == ST_AR) && (owner_q == REQ_ID) && s_arready;
            assign req_rvalid[gi]  = (state_q == ST_R)  && (owner_q == REQ_ID) && s_rvalid;
        end
    endgenerate

    assign ifu_arready = req_arready[0];
    assign lsu_arready = req_arready[1];
    assign ifu_rvalid  = req_rvalid[0];
    assign lsu_rvalid  = req_rvalid[1];

    // Response payload is broadcast; each requester qualifies it with its own rvalid.
    assign ifu_rdata = s_rdata;
    assign ifu_rresp = s_rresp;
    assign lsu_rdata = s_rdata;
    assign lsu_rresp = s_rresp;

    // Downstream port follows the owner only in the phase that uses it.
    assign s_araddr  = req_araddr[owner_q];
    assign s_arvalid = (state_q == ST_AR) && req_arvalid[owner_q];
    assign s_rready  = (state_q == ST_R)  && req_rready[owner_q];

    // State, owner and round-robin history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;    // IFU wins the first tie
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // Next-state: grant in IDLE, wait for AR handshake, then for R handshake.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_arvalid == 2'b11) begin
                    owner_d = ~last_q;
                    state_d = ST_AR;
                end else if (req_arvalid[1]) begin
                    owner_d = 1'b1;
                    state_d = ST_AR;
                end else if (req_arvalid[0]) begin
                    owner_d = 1'b0;
                    state_d = ST_AR;
                end
            end
            ST_AR: begin
                // If the owner withdraws arvalid we simply keep waiting here.
                if (s_arvalid && s_arready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (s_rvalid && s_rready) begin
                    state_d = ST_IDLE;
                    last_d  = owner_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060208_sram_rd_arbiter.sv
// Directed bench for the SRAM read arbiter; the bench plays both requesters and the SRAM.
module tb_ysyx_23060208_sram_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ifu_araddr = '0;
    logic        ifu_arvalid = 1'b0;
    logic        ifu_arready;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rvalid;
    logic        ifu_rready = 1'b0;
    logic [31:0] lsu_araddr = '0;
    logic        lsu_arvalid = 1'b0;
    logic        lsu_arready;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic        lsu_rvalid;
    logic        lsu_rready = 1'b0;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready = 1'b0;
    logic [31:0] s_rdata = '0;
    logic [1:0]  s_rresp = '0;
    logic        s_rvalid = 1'b0;
    logic        s_rready;

    int n_tests = 0;
    int n_fail  = 0;

    // Values captured by serve() for the scenario tasks to compare.
    int          cap_wait;
    logic [31:0] cap_addr;
    logic [1:0]  cap_arready;
    logic [1:0]  cap_rvalid;
    logic [31:0] cap_rdata;
    logic        cap_srready;

    ysyx_23060208_sram_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // SRAM model for one transaction: wait (bounded) for s_arvalid, accept the address,
    // return data one cycle later with both requesters ready. Ends back in IDLE.
    task automatic serve(input logic [31:0] data);
        #1;
        cap_wait = 0;
        while (!s_arvalid && cap_wait < 20) begin
            step();
            cap_wait++;
        end
        n_tests++;
        if (cap_wait >= 20) begin
            n_fail++;
            $display("FAIL serve_timeout: s_arvalid=%b after %0d cycles, required 1", s_arvalid, cap_wait);
        end
        s_arready = 1'b1;
        #1;
        cap_addr    = s_araddr;
        cap_arready = {lsu_arready, ifu_arready};
        step();
        if (cap_arready[0]) ifu_arvalid = 1'b0;
        if (cap_arready[1]) lsu_arvalid = 1'b0;
        s_arready  = 1'b0;
        s_rvalid   = 1'b1;
        s_rdata    = data;
        s_rresp    = 2'b00;
        ifu_rready = 1'b1;
        lsu_rready = 1'b1;
        #1;
        cap_rvalid  = {lsu_rvalid, ifu_rvalid};
        cap_rdata   = cap_rvalid[1] ? lsu_rdata : ifu_rdata;
        cap_srready = s_rready;
        step();
        s_rvalid   = 1'b0;
        ifu_rready = 1'b0;
        lsu_rready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        s_arready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h1234_5678;
        ifu_rready = 1'b1; lsu_rready = 1'b1;
        #1;
        n_tests++;
        if ({s_arvalid, s_rready, ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 000000",
                     {s_arvalid, s_rready, ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid});
        end
        n_tests++;
        if (lsu_rdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL rdata_broadcast: got %h required 12345678", lsu_rdata);
        end
        s_arready = 1'b0; s_rvalid = 1'b0; ifu_rready = 1'b0; lsu_rready = 1'b0;
        $display("[TB] test_reset done");
    endtask

    task automatic test_ifu_only();
        ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1;
        #1;
        n_tests++;
        if ({s_arvalid, ifu_arready} !== 2'b00) begin
            n_fail++;
            $display("FAIL ifu_idle_no_grant: s_arvalid,ifu_arready=%b required 00", {s_arvalid, ifu_arready});
        end
        step();
        n_tests++;
        if (s_arvalid !== 1'b1 || s_araddr !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL ifu_ar_n_plus_1: s_arvalid=%b s_araddr=%h required 1 80000000", s_arvalid, s_araddr);
        end
        n_tests++;
        if (ifu_arready !== 1'b0) begin
            n_fail++;
            $display("FAIL ifu_arready_follows: got %b required 0 while s_arready=0", ifu_arready);
        end
        serve(32'h0000_0413);
        n_tests++;
        if (cap_arready !== 2'b01 || cap_rvalid !== 2'b01 || cap_rdata !== 32'h413 || cap_srready !== 1'b1) begin
            n_fail++;
            $display("FAIL ifu_only_txn: arready=%b rvalid=%b rdata=%h s_rready=%b required 01 01 00000413 1",
                     cap_arready, cap_rvalid, cap_rdata, cap_srready);
        end
        #1;
        n_tests++;
        if ({ifu_rvalid, s_arvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL ifu_back_idle: ifu_rvalid,s_arvalid=%b required 00", {ifu_rvalid, s_arvalid});
        end
        $display("[TB] test_ifu_only done");
    endtask

    task automatic test_tie();
        do_reset();
        ifu_araddr = 32'h8000_0004; ifu_arvalid = 1'b1;
        lsu_araddr = 32'h8000_1000; lsu_arvalid = 1'b1;
        serve(32'h0000_0011);
        n_tests++;
        if (cap_arready !== 2'b01 || cap_addr !== 32'h8000_0004 || cap_rvalid !== 2'b01) begin
            n_fail++;
            $display("FAIL tie_first_ifu: arready=%b addr=%h rvalid=%b required 01 80000004 01",
                     cap_arready, cap_addr, cap_rvalid);
        end
        #1;
        n_tests++;
        if ({lsu_arready, s_arvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL tie_idle_gap: lsu_arready,s_arvalid=%b required 00", {lsu_arready, s_arvalid});
        end
        serve(32'h0000_0022);
        n_tests++;
        if (cap_wait !== 1 || cap_arready !== 2'b10 || cap_addr !== 32'h8000_1000 ||
            cap_rvalid !== 2'b10 || cap_rdata !== 32'h22) begin
            n_fail++;
            $display("FAIL tie_second_lsu: wait=%0d arready=%b addr=%h rvalid=%b rdata=%h required 1 10 80001000 10 00000022",
                     cap_wait, cap_arready, cap_addr, cap_rvalid, cap_rdata);
        end
        ifu_arvalid = 1'b1; lsu_arvalid = 1'b1;
        serve(32'h0000_0033);
        n_tests++;
        if (cap_arready !== 2'b01 || cap_addr !== 32'h8000_0004) begin
            n_fail++;
            $display("FAIL tie_rr_again_ifu: arready=%b addr=%h required 01 80000004", cap_arready, cap_addr);
        end
        serve(32'h0000_0044);
        n_tests++;
        if (cap_arready !== 2'b10 || cap_rdata !== 32'h44) begin
            n_fail++;
            $display("FAIL tie_rr_then_lsu: arready=%b rdata=%h required 10 00000044", cap_arready, cap_rdata);
        end
        $display("[TB] test_tie done");
    endtask

    task automatic test_pending();
        ifu_araddr = 32'h8000_0008; ifu_arvalid = 1'b1;
        step();
        s_arready = 1'b1;
        step();
        ifu_arvalid = 1'b0; s_arready = 1'b0;
        lsu_araddr = 32'h8000_2000; lsu_arvalid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_tests++;
            if ({lsu_arready, s_arvalid} !== 2'b00) begin
                n_fail++;
                $display("FAIL pend_during_r[%0d]: lsu_arready,s_arvalid=%b required 00", i, {lsu_arready, s_arvalid});
            end
            step();
        end
        s_rvalid = 1'b1; s_rdata = 32'h0000_0055; ifu_rready = 1'b1;
        #1;
        n_tests++;
        if (ifu_rvalid !== 1'b1 || lsu_rvalid !== 1'b0 || lsu_arready !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_ifu_r: ifu_rvalid=%b lsu_rvalid=%b lsu_arready=%b required 1 0 0",
                     ifu_rvalid, lsu_rvalid, lsu_arready);
        end
        step();
        s_rvalid = 1'b0; ifu_rready = 1'b0;
        #1;
        n_tests++;
        if ({lsu_arready, s_arvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL pend_idle_gap: lsu_arready,s_arvalid=%b required 00", {lsu_arready, s_arvalid});
        end
        step();
        n_tests++;
        if (s_arvalid !== 1'b1 || s_araddr !== 32'h8000_2000) begin
            n_fail++;
            $display("FAIL pend_lsu_granted: s_arvalid=%b s_araddr=%h required 1 80002000", s_arvalid, s_araddr);
        end
        serve(32'h0000_0066);
        n_tests++;
        if (cap_arready !== 2'b10 || cap_rdata !== 32'h66) begin
            n_fail++;
            $display("FAIL pend_lsu_txn: arready=%b rdata=%h required 10 00000066", cap_arready, cap_rdata);
        end
        $display("[TB] test_pending done");
    endtask

    task automatic test_backpressure();
        ifu_araddr = 32'h8000_0010; ifu_arvalid = 1'b1;
        step();
        s_arready = 1'b1;
        step();
        ifu_arvalid = 1'b0; s_arready = 1'b0;
        s_rvalid = 1'b1; s_rdata = 32'hCAFE_0001; s_rresp = 2'b10; ifu_rready = 1'b0;
        lsu_araddr = 32'h8000_4000; lsu_arvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (s_rready !== 1'b0 || ifu_rvalid !== 1'b1 || ifu_rdata !== 32'hCAFE_0001 ||
                lsu_arready !== 1'b0 || s_arvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: s_rready=%b ifu_rvalid=%b rdata=%h lsu_arready=%b s_arvalid=%b required 0 1 cafe0001 0 0",
                         i, s_rready, ifu_rvalid, ifu_rdata, lsu_arready, s_arvalid);
            end
            step();
        end
        ifu_rready = 1'b1;
        #1;
        n_tests++;
        if (s_rready !== 1'b1 || ifu_rresp !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_release: s_rready=%b ifu_rresp=%b required 1 10", s_rready, ifu_rresp);
        end
        step();
        s_rvalid = 1'b0; ifu_rready = 1'b0; s_rresp = 2'b00;
        serve(32'h0000_0077);
        n_tests++;
        if (cap_wait !== 1 || cap_arready !== 2'b10 || cap_addr !== 32'h8000_4000) begin
            n_fail++;
            $display("FAIL bp_lsu_after: wait=%0d arready=%b addr=%h required 1 10 80004000",
                     cap_wait, cap_arready, cap_addr);
        end
        $display("[TB] test_backpressure done");
    endtask

    task automatic test_reset_mid();
        // Finish an IFU transaction first so the round-robin pointer favours LSU.
        ifu_araddr = 32'h8000_0020; ifu_arvalid = 1'b1;
        serve(32'h0000_0001);
        ifu_araddr = 32'h8000_0024; ifu_arvalid = 1'b1;
        step();
        s_arready = 1'b1;
        step();
        ifu_arvalid = 1'b0; s_arready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        s_rvalid = 1'b1; s_arready = 1'b1; ifu_rready = 1'b1; lsu_rready = 1'b1;
        #1;
        n_tests++;
        if ({s_arvalid, s_rready, ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid} !== 6'b0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got %b required 000000",
                     {s_arvalid, s_rready, ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid});
        end
        s_rvalid = 1'b0; s_arready = 1'b0; ifu_rready = 1'b0; lsu_rready = 1'b0;
        ifu_araddr = 32'h8000_0028; ifu_arvalid = 1'b1;
        lsu_araddr = 32'h8000_5000; lsu_arvalid = 1'b1;
        serve(32'h0000_0088);
        n_tests++;
        if (cap_arready !== 2'b01 || cap_addr !== 32'h8000_0028 || cap_rdata !== 32'h88) begin
            n_fail++;
            $display("FAIL rstmid_last_reset: arready=%b addr=%h rdata=%h required 01 80000028 00000088",
                     cap_arready, cap_addr, cap_rdata);
        end
        serve(32'h0000_0099);
        n_tests++;
        if (cap_arready !== 2'b10 || cap_addr !== 32'h8000_5000) begin
            n_fail++;
            $display("FAIL rstmid_lsu_next: arready=%b addr=%h required 10 80005000", cap_arready, cap_addr);
        end
        $display("[TB] test_reset_mid done");
    endtask

    task automatic test_lsu_stream();
        int done;
        done = 0;
        for (int i = 0; i < 4; i++) begin
            lsu_araddr  = 32'h8000_3000 + 32'(4 * i);
            lsu_arvalid = 1'b1;
            serve(32'hA000_0000 + 32'(i));
            if (cap_rvalid == 2'b10) done++;
            n_tests++;
            if (cap_wait !== 1 || cap_arready !== 2'b10 || cap_addr !== 32'h8000_3000 + 32'(4 * i) ||
                cap_rdata !== 32'hA000_0000 + 32'(i)) begin
                n_fail++;
                $display("FAIL stream[%0d]: wait=%0d arready=%b addr=%h rdata=%h required 1 10 %h %h",
                         i, cap_wait, cap_arready, cap_addr, cap_rdata,
                         32'h8000_3000 + 32'(4 * i), 32'hA000_0000 + 32'(i));
            end
            $display("[TB] stream read %0d addr=%h data=%h", i, cap_addr, cap_rdata);
        end
        n_tests++;
        if (done !== 4) begin
            n_fail++;
            $display("FAIL stream_count: got %0d completions required 4", done);
        end
        $display("[TB] test_lsu_stream done");
    endtask

    initial begin
        test_reset();
        test_ifu_only();
        test_tie();
        test_pending();
        test_backpressure();
        test_reset_mid();
        test_lsu_stream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
